div_arbiter: RTL and testbench



---
 rtl/div_arbiter.sv | 147 ++++++++++++++
 tb/tb_div_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_arbiter.sv
// Round-robin arbiter that shares one iterative 32-bit divider among N requesters.
// It short-circuits divide-by-zero and aborts the divider through a watchdog.
module div_arbiter #(
   parameter int N       = 4,
   parameter int TIMEOUT = 40
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [N-1:0]    req_valid,
   input  logic [32*N-1:0] req_a,
   input  logic [32*N-1:0] req_b,
   output logic [N-1:0]    req_ready,
   output logic [N-1:0]    resp_valid,
   output logic [31:0]     resp_q,
   output logic [31:0]     resp_r,
   output logic            resp_err,
   output logic            div_start,
   output logic            div_reset,
   output logic [31:0]     div_a,
   output logic [31:0]     div_b,
   input  logic [31:0]     div_q,
   input  logic [31:0]     div_r,
   input  logic            div_ok,
   output logic [1:0]      dbg_state
);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

   // Handshake: request i is taken in the single cycle req_ready[i] is high; until then the
   // requester holds req_valid[i] and its operands, and may drop them earlier with no effect.

   state_t        state, state_nxt;
   logic [2:0]    ptr, owner, grant_idx;
   logic          grant_found, accept, abort_pulse, start_raw;
   logic [TW-1:0] timer;
   logic [31:0]   a_sel, b_sel;
   logic [7:0]    valid8, grant_oh8, owner_oh8;

   assign valid8 = 8'(req_valid);

   // Rotating priority: first valid index at or after the pointer, wrapping mod N.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int k = 0; k < N; k++) begin
         if (!grant_found && valid8[3'((int'(ptr) + k) % N)]) begin
            grant_found = 1'b1;
            grant_idx   = 3'((int'(ptr) + k) % N);
         end
      end
   end

   always_comb begin
      a_sel = '0;
      b_sel = '0;
      for (int k = 0; k < N; k++) begin
         if (grant_idx == 3'(k)) begin
            a_sel = req_a[32*k +: 32];
            b_sel = req_b[32*k +: 32];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      accept      = 1'b0;
      abort_pulse = 1'b0;
      start_raw   = 1'b0;
      case (state)
         IDLE: begin
            if (grant_found) begin
               accept    = 1'b1;
               state_nxt = (b_sel == '0) ? DONE : LOAD;
            end
         end
         LOAD: begin
            start_raw = 1'b1;
            state_nxt = RUN;
         end
         RUN: begin
            // Start must fall in the very cycle ok rises or the divider reloads.
            start_raw = !div_ok;
            if (div_ok) begin
               state_nxt = DONE;
            end else if (timer == TW'(TIMEOUT - 1)) begin
               abort_pulse = 1'b1;
               state_nxt   = DONE;
            end
         end
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ptr      <= '0;
         owner    <= '0;
         timer    <= '0;
         resp_q   <= '0;
         resp_r   <= '0;
         resp_err <= 1'b0;
         div_a    <= '0;
         div_b    <= '0;
      end else begin
         if (accept) begin
            div_a <= a_sel;
            div_b <= b_sel;
            owner <= grant_idx;
            ptr   <= 3'((int'(grant_idx) + 1) % N);
            if (b_sel == '0) begin
               resp_q   <= '1;
               resp_r   <= a_sel;
               resp_err <= 1'b1;
            end
         end
         if (state == LOAD) timer <= '0;
         if (state == RUN) begin
            if (div_ok) begin
               resp_q   <= div_q;
               resp_r   <= div_r;
               resp_err <= 1'b0;
            end else if (abort_pulse) begin
               resp_q   <= '0;
               resp_r   <= '0;
               resp_err <= 1'b1;
            end else begin
               timer <= timer + TW'(1);
            end
         end
      end
   end

   assign grant_oh8  = 8'(1) << grant_idx;
   assign owner_oh8  = 8'(1) << owner;
   assign req_ready  = (accept && reset_n) ? grant_oh8[N-1:0] : '0;
   assign resp_valid = (state == DONE && reset_n) ? owner_oh8[N-1:0] : '0;
   assign div_start  = start_raw & reset_n;
   assign div_reset  = !reset_n | abort_pulse;
   assign dbg_state  = state;
endmodule

// File: tb/tb_div_arbiter.sv
// Randomized bench for div_arbiter: behavioural divider, arbitration/timing reference model,
// and a response scoreboard fed at accept time and drained by a monitor.
module tb_div_arbiter;
   localparam int N       = 4;
   localparam int TIMEOUT = 40;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [32*N-1:0] req_a, req_b;
   logic [N-1:0]    req_ready, resp_valid;
   logic [31:0]     resp_q, resp_r, div_a, div_b;
   logic [31:0]     div_q = '0, div_r = '0;
   logic            resp_err, div_start, div_reset;
   logic            div_ok = 1'b1;
   logic [1:0]      dbg_state;

   logic [31:0] op_a[N];
   logic [31:0] op_b[N];
   int          acc_cnt[N];
   int          iss_cnt[N];
   logic        hang = 1'b0;

   int n_cmp = 0, n_bad = 0, cyc = 0;
   // {idx[2:0], q[31:0], r[31:0], err, resp_cycle[31:0]}
   logic [99:0] exp_q[$];

   // model state for arbitration and divider-control timing
   int m_ptr = 0, free_at = 0, s_lo = 1, s_hi = 0, abort_cyc = -1;

   for (genvar g = 0; g < N; g++) begin : g_pack
      assign req_a[32*g +: 32] = op_a[g];
      assign req_b[32*g +: 32] = op_b[g];
   end

   div_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .resp_valid(resp_valid), .resp_q(resp_q), .resp_r(resp_r),
      .resp_err(resp_err), .div_start(div_start), .div_reset(div_reset), .div_a(div_a),
      .div_b(div_b), .div_q(div_q), .div_r(div_r), .div_ok(div_ok), .dbg_state(dbg_state)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%h required=%h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic int rr_pick(logic [N-1:0] v, int p);
      logic [N-1:0] sh;
      for (int k = 0; k < N; k++) begin
         sh = v >> ((p + k) % N);
         if (sh[0]) return (p + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] onehot(int i);
      return N'(1) << i;
   endfunction

   // Divider: level start loads only while idle, 32 busy cycles, ok marks idle/done.
   initial begin : divider
      logic s_start, s_rst;
      logic [31:0] s_a, s_b, la, lb;
      int cnt;
      logic busy;
      busy = 1'b0; cnt = 0; la = '0; lb = '0;
      forever begin
         @(negedge clk);
         s_start = div_start; s_rst = div_reset; s_a = div_a; s_b = div_b;
         @(posedge clk);
         #1;
         if (s_rst) begin
            busy = 1'b0; div_ok = 1'b1; cnt = 0;
         end else if (s_start && div_ok && !busy) begin
            la = s_a; lb = s_b; busy = 1'b1; div_ok = 1'b0; cnt = 32;
         end else if (busy && !hang) begin
            if (cnt == 1) begin
               busy = 1'b0; div_ok = 1'b1;
               div_q = (lb == 0) ? '1 : la / lb;
               div_r = (lb == 0) ? la : la % lb;
            end
            cnt--;
         end
      end
   end

   // Monitor: reference arbitration, control-timing checks, scoreboard pop on resp_valid.
   initial begin : monitor
      int g;
      logic [N-1:0] exp_rdy;
      logic [31:0] a, b;
      logic [99:0] e;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            check("rst_req_ready", 32'(req_ready), 32'(0));
            check("rst_resp_valid", 32'(resp_valid), 32'(0));
            check("rst_div_start", 32'(div_start), 32'(0));
            check("rst_div_reset", 32'(div_reset), 32'(1));
            exp_q.delete();
            m_ptr = 0; free_at = cyc + 1; s_lo = 1; s_hi = 0; abort_cyc = -1;
         end else begin
            g = (cyc >= free_at) ? rr_pick(req_valid, m_ptr) : -1;
            exp_rdy = (g >= 0) ? onehot(g) : '0;
            check("req_ready", 32'(req_ready), 32'(exp_rdy));
            check("div_start", 32'(div_start), 32'(cyc >= s_lo && cyc <= s_hi));
            check("div_reset", 32'(div_reset), 32'(cyc == abort_cyc));
            if (g >= 0) begin
               acc_cnt[g]++;
               m_ptr = (g + 1) % N;
               a = op_a[g]; b = op_b[g];
               if (b == 0) begin
                  exp_q.push_back({3'(g), 32'hFFFF_FFFF, a, 1'b1, 32'(cyc + 1)});
                  free_at = cyc + 2;
               end else if (hang) begin
                  exp_q.push_back({3'(g), 32'h0, 32'h0, 1'b1, 32'(cyc + TIMEOUT + 2)});
                  s_lo = cyc + 1; s_hi = cyc + TIMEOUT + 1; abort_cyc = cyc + TIMEOUT + 1;
                  free_at = cyc + TIMEOUT + 3;
               end else begin
                  exp_q.push_back({3'(g), a / b, a % b, 1'b0, 32'(cyc + 35)});
                  s_lo = cyc + 1; s_hi = cyc + 33;
                  free_at = cyc + 36;
               end
            end
            if (resp_valid != '0) begin
               if (exp_q.size() == 0) begin
                  n_cmp++; n_bad++;
                  $display("FAIL resp_unexpected: actual=%b required=none at cycle %0d", resp_valid, cyc);
               end else begin
                  e = exp_q.pop_front();
                  check("resp_valid", 32'(resp_valid), 32'(onehot(int'(e[99:97]))));
                  check("resp_q", resp_q, e[96:65]);
                  check("resp_r", resp_r, e[64:33]);
                  check("resp_err", 32'(resp_err), 32'(e[32]));
                  check("resp_cycle", 32'(cyc), e[31:0]);
               end
            end else if (exp_q.size() != 0 && int'(exp_q[0][31:0]) < cyc) begin
               e = exp_q.pop_front();
               n_cmp++; n_bad++;
               $display("FAIL resp_missing: actual=none required=cycle %0d at cycle %0d", e[31:0], cyc);
            end
         end
      end
   end

   // driver tasks
   task automatic tick();
      logic [N-1:0] sh;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         sh = req_valid >> i;
         if (sh[0] && acc_cnt[i] == iss_cnt[i]) req_valid &= ~onehot(i);
      end
   endtask

   task automatic issue(int i, logic [31:0] a, logic [31:0] b);
      op_a[i] = a;
      op_b[i] = b;
      iss_cnt[i]++;
      req_valid |= onehot(i);
   endtask

   task automatic drain(string name);
      int t;
      t = 0;
      while ((req_valid != '0 || exp_q.size() != 0) && t < 3000) begin
         tick();
         t++;
      end
      n_cmp++;
      if (t >= 3000) begin
         n_bad++;
         $display("FAIL %s_drain: actual=%0d pending required=0 at cycle %0d", name, exp_q.size(), cyc);
      end
      tick();
   endtask

   initial begin : watchdog
      #500000;
      n_bad++;
      $display("FAIL watchdog: actual=timeout required=finish at cycle %0d", cyc);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      logic [N-1:0] sh;
      logic [31:0] ra, rb;
      int t;
      for (int i = 0; i < N; i++) begin op_a[i] = '0; op_b[i] = '0; end
      repeat (3) tick();
      check("reset_state", 32'(dbg_state), 32'(0));
      check("reset_resp_q", resp_q, 32'h0);
      check("reset_resp_r", resp_r, 32'h0);
      check("reset_resp_err", 32'(resp_err), 32'(0));
      check("reset_div_a", div_a, 32'h0);
      check("reset_div_b", div_b, 32'h0);
      reset_n = 1'b1;

      issue(0, 32'd100, 32'd7);
      drain("single");
      issue(2, 32'd55, 32'd0);
      drain("zero_div");

      // contention: requesters 0,1,3 waiting at reset release, then 0 again
      reset_n = 1'b0;
      issue(0, 32'd1000, 32'd3);
      issue(1, 32'd81, 32'd9);
      issue(3, 32'd12345, 32'd0);
      tick(); tick();
      reset_n = 1'b1;
      drain("contention");
      issue(0, 32'd77, 32'd8);
      drain("regrant");

      issue(1, 32'hFFFF_FFFF, 32'd1);
      issue(3, 32'd5, 32'd9);
      drain("edge_ops");

      hang = 1'b1;
      issue(1, 32'd77, 32'd3);
      drain("timeout");
      hang = 1'b0;
      issue(2, 32'd1000, 32'd10);
      drain("after_timeout");

      // reset ten cycles into an operation
      issue(3, 32'd999, 32'd13);
      t = 0;
      while (acc_cnt[3] != iss_cnt[3] && t < 200) begin tick(); t++; end
      repeat (9) tick();
      reset_n = 1'b0;
      tick();
      check("midreset_state", 32'(dbg_state), 32'(0));
      check("midreset_div_start", 32'(div_start), 32'(0));
      check("midreset_div_reset", 32'(div_reset), 32'(1));
      check("midreset_resp_valid", 32'(resp_valid), 32'(0));
      reset_n = 1'b1;
      issue(1, 32'd64, 32'd5);
      issue(0, 32'd100, 32'd7);
      drain("post_reset");

      // random traffic including early withdrawals
      for (int c = 0; c < 2500; c++) begin
         tick();
         for (int i = 0; i < N; i++) begin
            sh = req_valid >> i;
            if (!sh[0] && $urandom_range(0, 9) == 0) begin
               ra = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 100));
               case ($urandom_range(0, 7))
                  0:       rb = 32'h0;
                  1, 2, 3: rb = 32'($urandom_range(1, 16));
                  default: rb = $urandom;
               endcase
               issue(i, ra, rb);
            end else if (sh[0] && acc_cnt[i] != iss_cnt[i] && $urandom_range(0, 39) == 0) begin
               iss_cnt[i]--;
               req_valid &= ~onehot(i);
            end
         end
      end
      drain("random");

      check("final_queue_empty", 32'(exp_q.size()), 32'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
